// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transfer scheduler (CPU transfers + periodic driver polls).
package spi_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone
  } state_e;

  // Read/write flag of a datagram; 0 selects a register read.
  localparam int unsigned READ_BIT = 39;

  localparam logic [7:0] DEFAULT_POLL_ADDR = 8'h00;

  localparam logic [15:0] TIMEOUT_MAX = 16'hFFFF;

endpackage

// File: rtl/spi_sched_if.sv
// Scheduler <-> SPI master bus: the scheduler drives a datagram and chip select, the master
// answers with ready/data.
interface spi_sched_if #(
  parameter int unsigned SIZE = 40
);
  logic [SIZE-1:0] spi_data_out;
  logic            spi_send_en_out;
  logic [3:0]      spi_cs_out;
  logic [SIZE-1:0] spi_data_in;
  logic            spi_ready_in;

  modport master (
    output spi_data_out,
    output spi_send_en_out,
    output spi_cs_out,
    input  spi_data_in,
    input  spi_ready_in
  );

  modport slave (
    input  spi_data_out,
    input  spi_send_en_out,
    input  spi_cs_out,
    output spi_data_in,
    output spi_ready_in
  );
endinterface

// File: rtl/spi_sched_rr_pick.sv
// Round-robin picker: next set bit of the mask strictly after the last index, wrapping.
module rr_pick #(
  parameter int unsigned CS_COUNT = 12
) (
  input  logic [CS_COUNT-1:0] mask_i,
  input  logic [3:0]          last_i,
  output logic [3:0]          next_o,
  output logic                valid_o
);

  int unsigned cand;

  always_comb begin
    next_o  = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= CS_COUNT; i++) begin
      cand = (32'(last_i) + i) % CS_COUNT;
      if (!valid_o && mask_i[cand]) begin
        valid_o = 1'b1;
        next_o  = 4'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_sched.sv
// SPI scheduler: arbitrates CPU transfers against two-phase round-robin driver polls.
// Optional SPI_SCHED_TIMEOUT_EN adds a WAIT_BUSY/WAIT_DONE watchdog with a sticky error flag.
module spi_sched
  import spi_sched_pkg::*;
#(
  parameter int unsigned SIZE     = 40,
  parameter int unsigned CS_COUNT = 12,
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                cpu_req_in,
  input  logic [SIZE-1:0]     cpu_data_in,
  input  logic [3:0]          cpu_cs_in,
  output logic                cpu_ack_out,
  output logic [SIZE-1:0]     cpu_data_out,
  input  logic                poll_en_in,
  input  logic [CS_COUNT-1:0] poll_mask_in,
  input  logic [7:0]          poll_addr_in,
  input  logic [PERIOD_W-1:0] poll_period_in,
  output logic                stat_we_out,
  output logic [3:0]          stat_idx_out,
  output logic [31:0]         stat_data_out,
  spi_sched_if.master         spi,
  output logic                err_timeout_out
);

  state_e              state_q;
  logic                cpu_req_q;
  logic                cpu_hold_q;
  logic                src_cpu_q;
  logic                phase2_q;
  logic [3:0]          last_q;
  logic [PERIOD_W-1:0] timer_q;

  logic            cpu_pending;
  logic            cpu_cs_ok;
  logic            poll_due;
  logic [3:0]      pick_idx;
  logic            pick_valid;
  logic [SIZE-1:0] poll_word;

`ifdef SPI_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt_q;
`else
  assign err_timeout_out = 1'b0;
`endif

  rr_pick #(
    .CS_COUNT(CS_COUNT)
  ) u_rr_pick (
    .mask_i (poll_mask_in),
    .last_i (last_q),
    .next_o (pick_idx),
    .valid_o(pick_valid)
  );

  // Hold blocks a re-grant while the registered request still shows the acked transfer.
  assign cpu_pending = cpu_req_q & ~cpu_hold_q;
  assign cpu_cs_ok   = 32'(cpu_cs_in) < CS_COUNT;
  assign poll_due    = poll_en_in & (timer_q == '0) & pick_valid;

  always_comb begin
    poll_word                = '0;
    poll_word[SIZE-1 -: 8]   = poll_addr_in;
    poll_word[READ_BIT]      = 1'b0;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q             <= StIdle;
      cpu_req_q           <= 1'b0;
      cpu_hold_q          <= 1'b0;
      src_cpu_q           <= 1'b0;
      phase2_q            <= 1'b0;
      last_q              <= 4'(CS_COUNT - 1);
      timer_q             <= '0;
      cpu_ack_out         <= 1'b0;
      cpu_data_out        <= '0;
      stat_we_out         <= 1'b0;
      stat_idx_out        <= '0;
      stat_data_out       <= '0;
      spi.spi_data_out    <= '0;
      spi.spi_send_en_out <= 1'b0;
      spi.spi_cs_out      <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      to_cnt_q            <= '0;
      err_timeout_out     <= 1'b0;
`endif
    end else begin
      cpu_ack_out <= 1'b0;
      stat_we_out <= 1'b0;
      cpu_req_q   <= cpu_req_in;
      if (!cpu_req_q) cpu_hold_q <= 1'b0;
      if (timer_q != '0) timer_q <= timer_q - 1'b1;

      unique case (state_q)
        StIdle: begin
          if (cpu_pending && !cpu_cs_ok) begin
            cpu_ack_out  <= 1'b1;
            cpu_data_out <= '0;
            cpu_hold_q   <= 1'b1;
          end else if (spi.spi_ready_in && cpu_pending) begin
            src_cpu_q           <= 1'b1;
            phase2_q            <= 1'b0;
            spi.spi_data_out    <= cpu_data_in;
            spi.spi_cs_out      <= cpu_cs_in;
            spi.spi_send_en_out <= 1'b1;
            state_q             <= StStart;
          end else if (spi.spi_ready_in && poll_due) begin
            src_cpu_q           <= 1'b0;
            phase2_q            <= 1'b0;
            last_q              <= pick_idx;
            spi.spi_data_out    <= poll_word;
            spi.spi_cs_out      <= pick_idx;
            spi.spi_send_en_out <= 1'b1;
            state_q             <= StStart;
          end
        end
        StStart: state_q <= StWaitBusy;
        StWaitBusy: begin
          if (!spi.spi_ready_in) begin
            spi.spi_send_en_out <= 1'b0;
            state_q             <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (spi.spi_ready_in) begin
            if (src_cpu_q) begin
              cpu_ack_out  <= 1'b1;
              cpu_data_out <= spi.spi_data_in;
              cpu_hold_q   <= 1'b1;
              state_q      <= StIdle;
            end else if (!phase2_q) begin
              // Second poll phase reuses the latched datagram and index.
              phase2_q            <= 1'b1;
              spi.spi_send_en_out <= 1'b1;
              state_q             <= StStart;
            end else begin
              stat_we_out   <= 1'b1;
              stat_idx_out  <= spi.spi_cs_out;
              stat_data_out <= spi.spi_data_in[31:0];
              timer_q       <= poll_period_in;
              state_q       <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

`ifdef SPI_SCHED_TIMEOUT_EN
      if (state_q == StWaitBusy || state_q == StWaitDone) begin
        if (to_cnt_q == TIMEOUT_MAX) begin
          to_cnt_q            <= '0;
          err_timeout_out     <= 1'b1;
          spi.spi_send_en_out <= 1'b0;
          stat_we_out         <= 1'b0;
          phase2_q            <= 1'b0;
          state_q             <= StIdle;
          if (src_cpu_q) begin
            cpu_ack_out  <= 1'b1;
            cpu_data_out <= '0;
            cpu_hold_q   <= 1'b1;
          end else begin
            timer_q <= poll_period_in;
          end
        end else begin
          to_cnt_q <= to_cnt_q + 16'd1;
        end
      end else begin
        to_cnt_q <= '0;
      end
`endif
    end
  end

endmodule

// File: doc/spi_sched.md
SPI_SCHED -- requirements
Module: spi_sched

Interface
REQ-001 SHALL have parameter SIZE, default 40: SPI datagram width in bits.
REQ-002 SHALL have parameter CS_COUNT, default 12: number of driver chip selects.
REQ-003 SHALL have parameter PERIOD_W, default 24: width of the poll period counter.
REQ-004 SHALL have port clk_in, input, 1: the single clock.
REQ-005 SHALL have port reset_n_in, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port cpu_req_in, input, 1: CPU transfer request; held high until cpu_ack_out.
REQ-007 SHALL have ports cpu_data_in (input, SIZE) and cpu_cs_in (input, 4): CPU datagram and chip-select index.
REQ-008 SHALL have ports cpu_ack_out (output, 1) and cpu_data_out (output, SIZE): one-cycle done pulse, and the received datagram.
REQ-009 SHALL have ports poll_en_in (input, 1), poll_mask_in (input, CS_COUNT) and poll_addr_in (input, 8): enable, per-driver poll mask, and register address to poll.
REQ-010 SHALL have port poll_period_in, input, PERIOD_W: idle cycles between polls.
REQ-011 SHALL have ports stat_we_out (output, 1), stat_idx_out (output, 4) and stat_data_out (output, 32): poll-result write port.
REQ-012 SHALL have ports spi_data_out (output, SIZE), spi_send_en_out (output, 1), spi_cs_out (output, 4), spi_data_in (input, SIZE) and spi_ready_in (input, 1): interface to the SPI master.
REQ-013 SHALL have port err_timeout_out, output, 1: sticky timeout flag.

Function
REQ-014 SHALL implement the states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE, when spi_ready_in=1: a CPU request SHALL win over a due poll; the winner is latched and the block moves to START.
REQ-016 In START, spi_send_en_out SHALL be 1, with spi_data_out and spi_cs_out driven from the latched source; the block then moves to WAIT_BUSY.
REQ-017 In WAIT_BUSY, spi_send_en_out SHALL stay 1 until spi_ready_in=0; it is then driven 0 and the block moves to WAIT_DONE.
REQ-018 In WAIT_DONE, on spi_ready_in=1 the block SHALL capture spi_data_in and move to IDLE, unless a second poll phase is pending (REQ-021).
REQ-019 A CPU transfer SHALL pulse cpu_ack_out for exactly one cycle in the capture cycle, with cpu_data_out valid from that cycle until the next capture.
REQ-020 A poll datagram SHALL be {poll_addr_in, 32'h0}, with bit 39 = 0 (read).
REQ-021 A poll SHALL consist of two back-to-back transactions to the same index; the CPU SHALL NOT be granted between the two phases.
REQ-022 Second-phase capture SHALL pulse stat_we_out for one cycle, with stat_idx_out = the index and stat_data_out = spi_data_in[31:0].
REQ-023 The poll timer SHALL reload poll_period_in when a poll completes and decrement while nonzero; a poll is due when the timer is 0 and poll_en_in=1.
REQ-024 A poll_period_in of 0 SHALL give back-to-back polls.
REQ-025 The poll index SHALL be round-robin: next set bit of poll_mask_in after the last polled index, wrapping CS_COUNT-1 to 0.
REQ-026 poll_mask_in=0 SHALL mean no poll is ever due.
REQ-027 Clearing poll_en_in mid-poll SHALL let both phases finish; no new poll starts afterwards.
REQ-028 cpu_cs_in >= CS_COUNT SHALL be acked immediately with cpu_data_out=0 and no SPI activity.
REQ-029 The IDLE grant SHALL see only the registered cpu_req_in; cpu_req_in dropping before ack SHALL NOT abort a started transfer.

Reset
REQ-030 On reset_n_in=0, asynchronously: state=IDLE; all outputs 0; poll timer=0; last index=CS_COUNT-1; err_timeout_out=0.
REQ-031 Reset mid-transfer SHALL drop the transfer; after release the first poll goes to the lowest set mask bit.

Configuration
REQ-032 With SPI_SCHED_TIMEOUT_EN defined, a 16-bit counter SHALL run in WAIT_BUSY/WAIT_DONE; at 65535 the block returns to IDLE, sets err_timeout_out and acks any CPU transfer with cpu_data_out=0.
REQ-033 With SPI_SCHED_TIMEOUT_EN defined, err_timeout_out SHALL clear only on reset.
REQ-034 Without SPI_SCHED_TIMEOUT_EN, no counter SHALL exist and err_timeout_out SHALL be tied 0.

Structure
REQ-035 A shared package spi_sched_pkg SHALL hold the state enum, the read-bit position, the default poll address and TIMEOUT_MAX.
REQ-036 The single sub-module rr_pick SHALL be combinational: mask + last index -> next index + valid.

Verification
REQ-037 CPU req, cs=3, data=40'h80_0000_0001, SPI model busy for 40 cycles -> spi_cs_out=3, one cpu_ack_out, cpu_data_out = model response.
REQ-038 mask=12'b1000_0000_0101, period=100 -> stat_idx_out sequence 0,2,11,0; about 100 idle cycles between polls; two SPI transactions each.
REQ-039 CPU req raised during poll phase 1 -> phase 2 runs first, then the CPU transfer; no stat write is lost.
REQ-040 cpu_cs_in=13 -> cpu_ack_out within 2 cycles, cpu_data_out=0, spi_send_en_out stays 0.
REQ-041 (TIMEOUT_EN) model never drops spi_ready_in -> after 65535 cycles err_timeout_out=1 and state IDLE; next poll proceeds.
REQ-042 reset_n_in pulsed low in WAIT_DONE -> all outputs 0 immediately; the first poll after release goes to index 0.
